// File: rtl/serdes_pkg.sv
// Shared SerDes line-coding constants and TX state type.
// The constants are also used by the RX word aligner.
package serdes_pkg;

    localparam int LINE_WIDTH = 10;
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] TRAIN_PATTERN_DEF = 10'h2AA;

    typedef enum logic {
        TRAIN = 1'b0,
        DATA  = 1'b1
    } tx_state_t;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/tx_word_shifter.sv
// Word load/shift register with bit counter; emits the serial bit, the
// word-start flag and the boundary strobe (last bit of the current word).
module tx_word_shifter
    import serdes_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH,
    parameter logic [WIDTH-1:0] RESET_WORD = TRAIN_PATTERN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_word,
    output logic             serial,
    output logic             word_start,
    output logic             boundary
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= RESET_WORD;
            bit_cnt <= '0;
        end else if (boundary) begin
            shreg   <= load_word;
            bit_cnt <= '0;
        end else begin
            shreg   <= {1'b0, shreg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    assign serial     = shreg[0];
    assign word_start = (bit_cnt == '0);
    assign boundary   = (bit_cnt == LAST_BIT);

endmodule

// File: rtl/tx_serializer.sv
// SerDes TX serializer: training-burst / data state machine, training
// counter and valid/ready handshake around the word shifter.
module tx_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH,
    parameter int TRAIN_WORDS = 64,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter logic [WIDTH-1:0] IDLE_WORD = K28_5_RDN
) (
    input  logic             data_clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] TX_Data,
    input  logic             TX_Valid,
    output logic             TX_Ready,
    input  logic             Train_Req,
    output logic             Serial,
    output logic             Training,
    output logic             Word_Start
);

    localparam logic [9:0] TRAIN_LAST = 10'(TRAIN_WORDS - 1);

    tx_state_t        state, state_nx;
    logic [9:0]       train_cnt, train_cnt_nx;
    logic             train_pend, train_pend_nx;
    logic [WIDTH-1:0] load_word;
    logic             boundary;
    logic             train_hit;

    tx_word_shifter #(
        .WIDTH      (WIDTH),
        .RESET_WORD (TRAIN_PATTERN)
    ) u_shifter (
        .clk        (data_clock),
        .rst        (Reset),
        .load_word  (load_word),
        .serial     (Serial),
        .word_start (Word_Start),
        .boundary   (boundary)
    );

    always_ff @(posedge data_clock or posedge Reset) begin
        if (Reset) begin
            state      <= TRAIN;
            train_cnt  <= '0;
            train_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            train_cnt  <= train_cnt_nx;
            train_pend <= train_pend_nx;
        end
    end

    // A training request always beats a handshake at the same boundary.
    assign train_hit = Train_Req | train_pend;
    assign TX_Ready  = boundary && (state == DATA) && !train_hit;
    assign Training  = (state == TRAIN);

    always_comb begin
        state_nx      = state;
        train_cnt_nx  = train_cnt;
        train_pend_nx = train_pend;
        load_word     = IDLE_WORD;
        if (boundary) begin
            if (train_hit) begin
                state_nx      = TRAIN;
                train_cnt_nx  = '0;
                train_pend_nx = 1'b0;
                load_word     = TRAIN_PATTERN;
            end else if (state == TRAIN) begin
                if (train_cnt == TRAIN_LAST) begin
                    // burst done: the comma that follows lets the receiver align
                    state_nx  = DATA;
                    load_word = IDLE_WORD;
                end else begin
                    train_cnt_nx = train_cnt + 10'd1;
                    load_word    = TRAIN_PATTERN;
                end
            end else if (TX_Valid && TX_Ready) begin
                load_word = TX_Data;
            end else begin
                load_word = IDLE_WORD;
            end
        end else if (Train_Req) begin
            train_pend_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer with a word-level reference model.
module tb_tx_serializer;

    localparam int W  = 10;
    localparam int TW = 4;
    localparam logic [9:0] TP   = 10'h2AA;
    localparam logic [9:0] IDLE = 10'h17C;

    logic       data_clock = 1'b0;
    logic       Reset;
    logic [9:0] TX_Data;
    logic       TX_Valid;
    logic       TX_Ready;
    logic       Train_Req;
    logic       Serial;
    logic       Training;
    logic       Word_Start;

    tx_serializer #(.TRAIN_WORDS(TW)) dut (
        .data_clock (data_clock),
        .Reset      (Reset),
        .TX_Data    (TX_Data),
        .TX_Valid   (TX_Valid),
        .TX_Ready   (TX_Ready),
        .Train_Req  (Train_Req),
        .Serial     (Serial),
        .Training   (Training),
        .Word_Start (Word_Start)
    );

    always #5 data_clock = ~data_clock;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [3:0] lg [4096];      // {word_start, ready, training, serial}
    int acc_q[$];
    logic [9:0] src_q[$];
    logic valid_en;

    // reference model: current word, bit position, training words left
    logic [9:0] m_word;
    int m_idx;
    bit m_train;
    int m_left;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] lg_at(input int i);
        if (i >= 0 && i < 4096) return lg[i];
        return 4'bxxxx;
    endfunction

    function automatic int next_acc(input int after);
        foreach (acc_q[i]) if (acc_q[i] > after) return acc_q[i];
        return -1;
    endfunction

    task automatic m_reset();
        m_word = TP; m_idx = 0; m_train = 1; m_left = TW - 1; m_pend = 0;
    endtask

    task automatic tick();
        logic [9:0] d;
        bit v, req, mr;
        v = valid_en && (src_q.size() > 0);
        d = (src_q.size() > 0) ? src_q[0] : 10'h0;
        TX_Valid = v;
        TX_Data  = d;
        req = Train_Req;
        #2;
        mr = (m_idx == W - 1) && !m_train && !m_pend && !req;
        chk("serial", Serial, m_word[m_idx]);
        chk("training", Training, m_train);
        chk("word_start", Word_Start, m_idx == 0);
        chk("tx_ready", TX_Ready, mr);
        if (cyc < 4096) lg[cyc] = {Word_Start, TX_Ready, Training, Serial};
        if (v && TX_Ready === 1'b1) begin
            acc_q.push_back(cyc);
            void'(src_q.pop_front());
        end
        if (m_idx != W - 1) begin
            m_idx++;
            if (req) m_pend = 1;
        end else begin
            m_idx = 0;
            if (req || m_pend) begin
                m_word = TP; m_train = 1; m_left = TW - 1; m_pend = 0;
            end else if (m_train && m_left == 0) begin
                m_train = 0; m_word = IDLE;
            end else if (m_train) begin
                m_left--; m_word = TP;
            end else if (v && mr) begin
                m_word = d;
            end else begin
                m_word = IDLE;
            end
        end
        @(posedge data_clock);
        #1;
        Train_Req = 1'b0;
        cyc++;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_accept(input int budget, input string tag, output int k);
        int n0;
        n0 = acc_q.size();
        k = -1;
        for (int i = 0; i < budget && acc_q.size() == n0; i++) tick();
        if (acc_q.size() > n0) k = acc_q[n0];
        chk(tag, acc_q.size() > n0, 1'b1);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        #1;
        chk("rst_serial", Serial, 1'b0);
        chk("rst_training", Training, 1'b1);
        chk("rst_word_start", Word_Start, 1'b1);
        chk("rst_tx_ready", TX_Ready, 1'b0);
        @(posedge data_clock);
        #1;
        Reset = 1'b0;
        src_q.delete();
        acc_q.delete();
        Train_Req = 1'b0;
        TX_Valid = 1'b0;
        valid_en = 1'b0;
        m_reset();
        cyc = 0;
    endtask

    initial begin
        logic [0:9] idle_seq;
        int ka, kb, k, kk, kn, k2;
        idle_seq = 10'b0011111010;
        Reset = 1'b1; Train_Req = 1'b0; TX_Valid = 1'b0; TX_Data = '0;
        valid_en = 1'b0; cyc = 0;

        // 1: training burst then idle commas, no data offered
        apply_reset();
        tick_to(50);
        for (int i = 0; i < 40; i++) chk("train_bits", lg_at(i)[0], i % 2);
        for (int i = 0; i < 10; i++) chk("idle_bits", lg_at(40 + i)[0], idle_seq[i]);
        chk("training_39", lg_at(39)[1], 1'b1);
        chk("training_40", lg_at(40)[1], 1'b0);
        for (int i = 0; i < 4; i++) chk("word_start_pulse", lg_at(10 * i)[3], 1'b1);
        chk("word_start_mid", lg_at(5)[3], 1'b0);
        chk("ready_48", lg_at(48)[2], 1'b0);
        chk("ready_49", lg_at(49)[2], 1'b1);

        // 2: first acceptance latency and LSB-first order
        apply_reset();
        src_q.push_back(10'h3FF);
        src_q.push_back(10'h001);
        valid_en = 1'b1;
        tick_to(75);
        chk("acc_count", acc_q.size(), 2);
        chk("first_accept", next_acc(-1), 49);
        chk("second_accept", next_acc(49), 59);
        for (int i = 50; i < 60; i++) chk("word_3ff", lg_at(i)[0], 1'b1);
        chk("word_001_b0", lg_at(60)[0], 1'b1);
        for (int i = 61; i < 70; i++) chk("word_001_hi", lg_at(i)[0], 1'b0);

        // 3: one-boundary stall inserts exactly one comma
        src_q.push_back(10'($urandom));
        wait_accept(30, "stall_a_seen", ka);
        valid_en = 1'b0;
        src_q.push_back(10'($urandom));
        tick_to(ka + 11);
        valid_en = 1'b1;
        wait_accept(30, "stall_b_seen", kb);
        chk("stall_gap", kb - ka, 20);
        for (int i = 0; i < 10; i++) chk("stall_idle", lg_at(ka + 11 + i)[0], idle_seq[i]);

        // 4: training request mid-word becomes pending
        for (int i = 0; i < 6; i++) src_q.push_back(10'($urandom));
        wait_accept(30, "pend_seen", k);
        tick_to(k + 4);
        Train_Req = 1'b1;
        tick();
        tick_to(k + 62);
        chk("pend_ready_low", lg_at(k + 10)[2], 1'b0);
        chk("pend_train_start", lg_at(k + 11)[1], 1'b1);
        chk("pend_train_last", lg_at(k + 50)[1], 1'b1);
        chk("pend_train_end", lg_at(k + 51)[1], 1'b0);
        chk("pend_resume", next_acc(k), k + 60);

        // 5: training request coincident with a handshake opportunity
        for (int i = 0; i < 4; i++) src_q.push_back(10'($urandom));
        wait_accept(30, "coinc_prev_seen", kk);
        tick_to(kk + 10);
        Train_Req = 1'b1;
        tick();
        wait_accept(80, "coinc_held_seen", kn);
        chk("coinc_ready_low", lg_at(kk + 10)[2], 1'b0);
        chk("coinc_resume", kn, kk + 60);

        // 6: reset in the middle of a data word
        for (int i = 0; i < 300 && src_q.size() > 0; i++) tick();
        chk("drain_empty", src_q.size(), 0);
        src_q.push_back(10'h3FF);
        wait_accept(30, "mid_word_seen", k2);
        tick_to(k2 + 6);
        #2;
        chk("pre_reset_serial", Serial, 1'b1);
        apply_reset();
        tick_to(50);
        chk("rerun_training_39", lg_at(39)[1], 1'b1);
        chk("rerun_training_40", lg_at(40)[1], 1'b0);

        // 7: random traffic against the model
        valid_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (src_q.size() < 3) src_q.push_back(10'($urandom));
            valid_en = ($urandom_range(0, 3) != 0);
            Train_Req = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
